// File: rtl/axis_crc32_mpeg2_check.sv
// CRC-32/MPEG-2 receive checker: strips the trailing CRC beat, forwards payload
// with tlast moved onto the final payload beat, and pulses a per-packet status.
module axis_crc32_mpeg2_check #(
    parameter int          AXI_DATA_WIDTH = 32,
    parameter logic [31:0] INIT_CRC       = 32'hFFFFFFFF,
    parameter logic [31:0] POLY_CRC       = 32'h04C11DB7
) (
    input  logic                      aclk,
    input  logic                      aresetn,
    input  logic [AXI_DATA_WIDTH-1:0] s_axis_tdata,
    input  logic                      s_axis_tvalid,
    output logic                      s_axis_tready,
    input  logic                      s_axis_tlast,
    output logic [AXI_DATA_WIDTH-1:0] m_axis_tdata,
    output logic                      m_axis_tvalid,
    input  logic                      m_axis_tready,
    output logic                      m_axis_tlast,
    output logic                      crc_done,
    output logic                      crc_ok,
    output logic [31:0]               crc_calc
);

    function automatic logic [31:0] step32(input logic [31:0] c_in);
        logic [31:0] c;
        c = c_in;
        for (int i = 0; i < 32; i++) begin
            if (c[31]) c = {c[30:0], 1'b0} ^ POLY_CRC;
            else       c = {c[30:0], 1'b0};
        end
        return c;
    endfunction

    logic [AXI_DATA_WIDTH-1:0] h_data;
    logic                      h_valid;
    logic [AXI_DATA_WIDTH-1:0] o_data;
    logic                      o_last;
    logic                      o_valid;
    logic [31:0]               acc;
    logic [31:0]               acc_next;
    logic                      accept;

    // The hold register delays each payload beat by one so tlast can be
    // placed on it once the following beat turns out to be the CRC word.
    assign s_axis_tready = !h_valid || !o_valid || m_axis_tready;
    assign accept        = s_axis_tvalid && s_axis_tready;
    assign acc_next      = step32(acc ^ s_axis_tdata);

    assign m_axis_tdata  = o_data;
    assign m_axis_tlast  = o_last;
    assign m_axis_tvalid = o_valid;

    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            h_data   <= '0;
            h_valid  <= 1'b0;
            o_data   <= '0;
            o_last   <= 1'b0;
            o_valid  <= 1'b0;
            acc      <= INIT_CRC;
            crc_done <= 1'b0;
            crc_ok   <= 1'b0;
            crc_calc <= '0;
        end else begin
            crc_done <= 1'b0;
            if (o_valid && m_axis_tready) begin
                o_valid <= 1'b0;
            end
            if (accept && h_valid) begin
                o_data  <= h_data;
                o_last  <= s_axis_tlast;
                o_valid <= 1'b1;
            end
            if (accept) begin
                if (s_axis_tlast) begin
                    crc_calc <= acc;
                    crc_ok   <= (acc == s_axis_tdata);
                    crc_done <= 1'b1;
                    h_valid  <= 1'b0;
                    acc      <= INIT_CRC;
                end else begin
                    acc      <= acc_next;
                    h_data   <= s_axis_tdata;
                    h_valid  <= 1'b1;
                end
            end
        end
    end

endmodule
